// File: rtl/sky130_sram_1rw1r_param.sv
// Parameterised 1RW + 1R synchronous SRAM model with byte-group write mask,
// optional output register, selectable collision behaviour and post-reset zero-fill.
module sky130_sram_1rw1r_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int WMASK_WIDTH  = 4,
    parameter bit OUT_REG      = 1'b0,
    parameter bit COLLIDE_MODE = 1'b0,
    parameter bit INIT_ZERO    = 1'b1
) (
`ifdef USE_POWER_PINS
    inout  wire                    vccd1,
    inout  wire                    vssd1,
`endif
    input  logic                   clk0,
    input  logic                   rstb0,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   dout0_vld,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dout1_vld,
    output logic                   collision1,
    output logic                   busy
);

    localparam int GROUP     = DATA_WIDTH / WMASK_WIDTH;
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t                  state_r, state_nx_s;
    logic [ADDR_WIDTH-1:0]   fill_cnt_r;
    logic [DATA_WIDTH-1:0]   mem_r [RAM_DEPTH];

    logic                    wr_req_r, rd0_req_r, rd1_req_r;
    logic [WMASK_WIDTH-1:0]  wmask_r;
    logic [ADDR_WIDTH-1:0]   addr0_r, addr1_r;
    logic [DATA_WIDTH-1:0]   din0_r;

    logic                    accept_s, collide_s;
    logic [DATA_WIDTH-1:0]   rd0_word_s, rd1_word_s;

    logic                    s1_vld0_r, s1_vld1_r, s1_col_r;
    logic [DATA_WIDTH-1:0]   s1_dout0_r, s1_dout1_r;

    // Lay the enabled groups of new_word over old_word.
    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0]  old_word,
        input logic [DATA_WIDTH-1:0]  new_word,
        input logic [WMASK_WIDTH-1:0] mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int g = 0; g < WMASK_WIDTH; g++) begin
            if (mask[g]) begin
                res[g*GROUP +: GROUP] = new_word[g*GROUP +: GROUP];
            end
        end
        return res;
    endfunction

    assign busy      = (state_r == CLEAR);
    assign accept_s  = (state_r == READY);
    assign collide_s = wr_req_r & rd1_req_r & (addr0_r == addr1_r);

    // Zero-fill FSM next state: leave CLEAR once the last address is written.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            CLEAR:   begin
                if (fill_cnt_r == {ADDR_WIDTH{1'b1}}) state_nx_s = READY;
                else                                  state_nx_s = CLEAR;
            end
            READY:   state_nx_s = READY;
            default: state_nx_s = READY;
        endcase
    end

    // FSM state and fill address counter.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state_r    <= INIT_ZERO ? CLEAR : READY;
            fill_cnt_r <= '0;
        end else begin
            state_r <= state_nx_s;
            if (state_r == CLEAR) fill_cnt_r <= fill_cnt_r + ADDR_WIDTH'(1);
            else                  fill_cnt_r <= '0;
        end
    end

    // Input sampling; requests only become valid while the array is ready.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            wr_req_r  <= 1'b0;
            rd0_req_r <= 1'b0;
            rd1_req_r <= 1'b0;
            wmask_r   <= '0;
            addr0_r   <= '0;
            addr1_r   <= '0;
            din0_r    <= '0;
        end else begin
            wr_req_r  <= accept_s & ~csb0 & ~web0;
            rd0_req_r <= accept_s & ~csb0 &  web0;
            rd1_req_r <= accept_s & ~csb1;
            wmask_r   <= wmask0;
            addr0_r   <= addr0;
            addr1_r   <= addr1;
            din0_r    <= din0;
        end
    end

    // Storage array: fill writes take precedence over (impossible) concurrent user writes.
    always_ff @(posedge clk0) begin
        if (state_r == CLEAR) begin
            mem_r[fill_cnt_r] <= '0;
        end else if (wr_req_r) begin
            mem_r[addr0_r] <= merge_word(mem_r[addr0_r], din0_r, wmask_r);
        end
    end

    // Array read words; a write-through collision sees the merged word.
    always_comb begin
        rd0_word_s = mem_r[addr0_r];
        if (COLLIDE_MODE && collide_s) rd1_word_s = merge_word(mem_r[addr1_r], din0_r, wmask_r);
        else                           rd1_word_s = mem_r[addr1_r];
    end

    // First read stage; data registers hold their value between reads.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            s1_vld0_r  <= 1'b0;
            s1_vld1_r  <= 1'b0;
            s1_col_r   <= 1'b0;
            s1_dout0_r <= '0;
            s1_dout1_r <= '0;
        end else begin
            s1_vld0_r <= rd0_req_r;
            s1_vld1_r <= rd1_req_r;
            s1_col_r  <= collide_s;
            if (rd0_req_r) s1_dout0_r <= rd0_word_s;
            if (rd1_req_r) s1_dout1_r <= rd1_word_s;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            // Optional second read stage adding one cycle of latency.
            always_ff @(posedge clk0 or negedge rstb0) begin
                if (!rstb0) begin
                    dout0_vld  <= 1'b0;
                    dout1_vld  <= 1'b0;
                    collision1 <= 1'b0;
                    dout0      <= '0;
                    dout1      <= '0;
                end else begin
                    dout0_vld  <= s1_vld0_r;
                    dout1_vld  <= s1_vld1_r;
                    collision1 <= s1_col_r;
                    if (s1_vld0_r) dout0 <= s1_dout0_r;
                    if (s1_vld1_r) dout1 <= s1_dout1_r;
                end
            end
        end else begin : g_no_out_reg
            assign dout0_vld  = s1_vld0_r;
            assign dout1_vld  = s1_vld1_r;
            assign collision1 = s1_col_r;
            assign dout0      = s1_dout0_r;
            assign dout1      = s1_dout1_r;
        end
    endgenerate

endmodule

// File: tb/tb_sky130_sram_1rw1r_param.sv
// Directed bench: two instances sharing stimulus, (OUT_REG=0, read-old) and
// (OUT_REG=1, write-through), checked against a hand-computed vector table.
module tb_sky130_sram_1rw1r_param;

    logic        clk = 1'b0;
    logic        rstb0, csb0, web0, csb1;
    logic [3:0]  wmask0, addr0, addr1;
    logic [31:0] din0;

    logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
    logic        vld0_a, vld1_a, col_a, busy_a;
    logic        vld0_b, vld1_b, col_b, busy_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sky130_sram_1rw1r_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .WMASK_WIDTH(4),
        .OUT_REG(1'b0), .COLLIDE_MODE(1'b0), .INIT_ZERO(1'b1)
    ) dut_a (
        .clk0(clk), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(dout0_a), .dout0_vld(vld0_a),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_a), .dout1_vld(vld1_a),
        .collision1(col_a), .busy(busy_a)
    );

    sky130_sram_1rw1r_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .WMASK_WIDTH(4),
        .OUT_REG(1'b1), .COLLIDE_MODE(1'b1), .INIT_ZERO(1'b1)
    ) dut_b (
        .clk0(clk), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(dout0_b), .dout0_vld(vld0_b),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_b), .dout1_vld(vld1_b),
        .collision1(col_b), .busy(busy_b)
    );

    // Inputs for one cycle, plus what dut_a shows after that cycle's edge
    // (the result of the previous vector's request). e_d1m1 is dout1 under write-through.
    typedef struct {
        logic        csb0;
        logic        web0;
        logic [3:0]  wmask0;
        logic [3:0]  addr0;
        logic [31:0] din0;
        logic        csb1;
        logic [3:0]  addr1;
        logic        e_vld0;
        logic [31:0] e_dout0;
        logic        e_vld1;
        logic [31:0] e_dout1;
        logic [31:0] e_d1m1;
        logic        e_col;
    } vec_t;

    vec_t tbl [16];
    vec_t prv;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 4'h0;
        din0 = 32'h0; csb1 = 1'b1; addr1 = 4'h0;
    endtask

    // Step until dut_a leaves busy (bounded); optionally fire a write+read at one cycle.
    task automatic fill_wait(input int inject_at, output int n, output logic saw);
        n = 0;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == inject_at) begin
                csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 4'd7;
                din0 = 32'hDEADBEEF; csb1 = 1'b0; addr1 = 4'd7;
            end else begin
                idle();
            end
            step();
            n++;
            saw = saw | vld0_a | vld1_a | col_a | vld0_b | vld1_b | col_b;
            if (!busy_a) break;
        end
        idle();
    endtask

    initial begin
        int   n;
        logic saw;
        logic [3:0] av;

        tbl[0]  = '{1'b0, 1'b0, 4'hF, 4'd3, 32'hAABBCCDD, 1'b1, 4'd0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b0, 4'h5, 4'd3, 32'h11223344, 1'b1, 4'd0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b1, 4'h0, 4'd0, 32'h0,        1'b0, 4'd3, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'h0, 4'd3, 32'h0,        1'b1, 4'd0, 1'b0, 32'h0,        1'b1, 32'hAA22CC44, 32'hAA22CC44, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 4'hF, 4'd5, 32'h0,        1'b1, 4'd0, 1'b1, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 32'hAA22CC44, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 4'hF, 4'd5, 32'hFFFFFFFF, 1'b0, 4'd5, 1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 32'hAA22CC44, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 4'h0, 4'd0, 32'h0,        1'b1, 4'd0, 1'b0, 32'hAA22CC44, 1'b1, 32'h0,        32'hFFFFFFFF, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 4'h0, 4'd5, 32'h0,        1'b0, 4'd5, 1'b0, 32'hAA22CC44, 1'b0, 32'h0,        32'hFFFFFFFF, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 4'd5, 32'h12345678, 1'b0, 4'd5, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'h0, 4'd3, 32'h0,        1'b0, 4'd5, 1'b0, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 4'h0, 4'd5, 32'h0,        1'b0, 4'd3, 1'b1, 32'hAA22CC44, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 4'h1, 4'd3, 32'h000000EE, 1'b0, 4'd3, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hAA22CC44, 32'hAA22CC44, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 4'h0, 4'd0, 32'h0,        1'b1, 4'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 32'hAA22CC44, 32'hAA22CCEE, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 4'h0, 4'd3, 32'h0,        1'b1, 4'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hAA22CC44, 32'hAA22CCEE, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 4'h0, 4'd0, 32'h0,        1'b1, 4'd0, 1'b1, 32'hAA22CCEE, 1'b0, 32'hAA22CC44, 32'hAA22CCEE, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 4'h0, 4'd0, 32'h0,        1'b1, 4'd0, 1'b0, 32'hAA22CCEE, 1'b0, 32'hAA22CC44, 32'hAA22CCEE, 1'b0};

        idle();
        rstb0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy_a", busy_a, 1'b1);
        chk1("rst_busy_b", busy_b, 1'b1);
        chk32("rst_dout0_a", dout0_a, 32'h0);
        chk32("rst_dout1_a", dout1_a, 32'h0);
        chk1("rst_vld0_a", vld0_a, 1'b0);
        chk1("rst_col_a", col_a, 1'b0);
        chk32("rst_dout1_b", dout1_b, 32'h0);

        // Fill after first release, with a write+read attempted while busy.
        rstb0 = 1'b1;
        chk1("busy_at_release", busy_a, 1'b1);
        fill_wait(3, n, saw);
        chk32("fill_cycles", 32'(n), 32'd16);
        chk1("fill_quiet", saw, 1'b0);
        chk1("busy_b_ready", busy_b, 1'b0);

        // Every address reads zero on both ports; latency 1 (dut_a) vs 2 (dut_b).
        for (int a = 0; a < 16; a++) begin
            av = a[3:0];
            csb0 = 1'b0; web0 = 1'b1; addr0 = av; csb1 = 1'b0; addr1 = 4'd15 - av;
            step();
            idle();
            step();
            chk1("zr_vld0_a", vld0_a, 1'b1);
            chk32("zr_dout0_a", dout0_a, 32'h0);
            chk1("zr_vld1_a", vld1_a, 1'b1);
            chk32("zr_dout1_a", dout1_a, 32'h0);
            chk1("zr_vld0_b_early", vld0_b, 1'b0);
            step();
            chk1("zr_vld0_a_pulse", vld0_a, 1'b0);
            chk1("zr_vld0_b", vld0_b, 1'b1);
            chk32("zr_dout0_b", dout0_b, 32'h0);
        end

        // Table: dut_a against this row, dut_b against the previous row.
        prv = '{1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
        for (int k = 0; k < 16; k++) begin
            csb0 = tbl[k].csb0; web0 = tbl[k].web0; wmask0 = tbl[k].wmask0;
            addr0 = tbl[k].addr0; din0 = tbl[k].din0; csb1 = tbl[k].csb1; addr1 = tbl[k].addr1;
            step();
            chk1("tv_vld0_a", vld0_a, tbl[k].e_vld0);
            chk32("tv_dout0_a", dout0_a, tbl[k].e_dout0);
            chk1("tv_vld1_a", vld1_a, tbl[k].e_vld1);
            chk32("tv_dout1_a", dout1_a, tbl[k].e_dout1);
            chk1("tv_col_a", col_a, tbl[k].e_col);
            chk1("tv_vld0_b", vld0_b, prv.e_vld0);
            chk32("tv_dout0_b", dout0_b, prv.e_dout0);
            chk1("tv_vld1_b", vld1_b, prv.e_vld1);
            chk32("tv_dout1_b", dout1_b, prv.e_d1m1);
            chk1("tv_col_b", col_b, prv.e_col);
            prv = tbl[k];
        end
        idle();
        step();

        // Reset with reads in flight: outputs clear at once, no vld afterwards.
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3; csb1 = 1'b0; addr1 = 4'd3;
        step();
        idle();
        #2;
        rstb0 = 1'b0;
        #1;
        chk32("mr_dout0_a", dout0_a, 32'h0);
        chk32("mr_dout1_a", dout1_a, 32'h0);
        chk32("mr_dout0_b", dout0_b, 32'h0);
        chk1("mr_vld0_a", vld0_a, 1'b0);
        chk1("mr_busy_a", busy_a, 1'b1);
        @(negedge clk);
        rstb0 = 1'b1;

        // Reset again at fill cycle 7; the fill must restart and last 16 cycles.
        saw = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            saw = saw | vld0_a | vld1_a | col_a | vld0_b | vld1_b | col_b;
        end
        chk1("mf_busy_before", busy_a, 1'b1);
        #2;
        rstb0 = 1'b0;
        #1;
        chk1("mf_busy_rst", busy_a, 1'b1);
        chk32("mf_dout0_a", dout0_a, 32'h0);
        chk1("mf_vld1_b", vld1_b, 1'b0);
        @(negedge clk);
        rstb0 = 1'b1;
        chk1("mf_quiet_pre", saw, 1'b0);
        fill_wait(-1, n, saw);
        chk32("refill_cycles", 32'(n), 32'd16);
        chk1("refill_quiet", saw, 1'b0);

        // Array was re-zeroed: addr 3 (was 0xAA22CCEE) and addr 5 read 0.
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3; csb1 = 1'b0; addr1 = 4'd5;
        step();
        idle();
        step();
        chk1("rz_vld0_a", vld0_a, 1'b1);
        chk32("rz_dout0_a", dout0_a, 32'h0);
        chk32("rz_dout1_a", dout1_a, 32'h0);
        step();
        chk1("rz_vld1_b", vld1_b, 1'b1);
        chk32("rz_dout1_b", dout1_b, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sky130_sram_1rw1r_param.md
SKY130_SRAM_1RW1R_PARAM -- requirements
Module: sky130_sram_1rw1r_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8; depth RAM_DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter WMASK_WIDTH, default 4; DATA_WIDTH divisible by WMASK_WIDTH; mask bit i covers word bits [i*G +: G], G = DATA_WIDTH/WMASK_WIDTH.
REQ-004 SHALL have parameter OUT_REG, default 0; 1 adds an output register stage.
REQ-005 SHALL have parameter COLLIDE_MODE, default 0; 0 = read-old, 1 = write-through on collision.
REQ-006 SHALL have parameter INIT_ZERO, default 1; 1 = zero-fill array after reset.
REQ-007 SHALL have the one clock and reset decided for this block: clk0 input 1 (single clock, all logic on posedge); rstb0 input 1 (asynchronous, active-low reset).
REQ-008 SHALL have vccd1 and vssd1 inout 1, present only under USE_POWER_PINS.
REQ-009 SHALL have csb0 input 1, port 0 active-low select; web0 input 1, port 0 active-low write.
REQ-010 SHALL have wmask0 input WMASK_WIDTH, write mask; addr0 input ADDR_WIDTH; din0 input DATA_WIDTH.
REQ-011 SHALL have dout0 output DATA_WIDTH, port 0 read data; dout0_vld output 1, read data valid.
REQ-012 SHALL have csb1 input 1, port 1 active-low select; addr1 input ADDR_WIDTH.
REQ-013 SHALL have dout1 output DATA_WIDTH; dout1_vld output 1; collision1 output 1, flags a collided read.
REQ-014 SHALL have busy output 1, high while zero-fill runs.

Function
REQ-015 SHALL sample all port inputs at posedge clk0 (cycle N); a request is accepted only when busy=0 at that edge.
REQ-016 SHALL perform a port 0 write (csb0=0, web0=0) at the edge following acceptance, updating only groups with wmask0 bit=1; wmask0=0 writes nothing, and no dout0_vld is produced.
REQ-017 SHALL perform a port 0 read (csb0=0, web0=1) and a port 1 read (csb1=0), with read latency L = 1 + OUT_REG cycles: dout/vld valid after posedge N+L.
REQ-018 SHALL pulse each dout*_vld high for exactly one cycle per accepted read; back-to-back reads give one vld per cycle.
REQ-019 SHALL hold dout0/dout1 at the last read value when no read completes; outputs are never X after reset.
REQ-020 SHALL define collision as an accepted port 0 write and an accepted port 1 read to the same address in the same cycle N.
REQ-021 SHALL, on collision with COLLIDE_MODE=0, return pre-write contents on dout1; with COLLIDE_MODE=1, return the merged word (masked din0 over old data).
REQ-022 SHALL assert collision1 together with the corresponding dout1_vld, for one cycle; masked-off-only writes (wmask0=0) SHALL still flag.
REQ-023 SHALL return the just-written data for a read issued in cycle N+1 or later to an address written in cycle N, on either port.
REQ-024 SHALL implement zero-fill FSM states CLEAR and READY: reset enters CLEAR if INIT_ZERO=1, else READY.
REQ-025 SHALL in CLEAR write zero to one address per cycle, counter 0 to RAM_DEPTH-1, busy=1; after the last address, go to READY, busy=0 the next cycle; fill takes RAM_DEPTH cycles.
REQ-026 SHALL ignore requests while busy=1: no array change, no vld, no collision1.
REQ-027 SHALL leave array contents undefined after reset when INIT_ZERO=0.

Reset
REQ-028 SHALL, on rstb0 low, immediately clear dout0, dout1 to 0, all vld, collision1, and pipeline valids to 0, and the fill counter to 0; busy = INIT_ZERO.
REQ-029 SHALL, on reset asserted mid-fill or mid-read, abort the operation, discard in-flight reads (no vld after release), and restart fill from address 0.
REQ-030 SHALL begin operation on the first posedge clk0 after rstb0 deasserts.

Verification (DATA_WIDTH=32, ADDR_WIDTH=4, WMASK_WIDTH=4)
REQ-031 SHALL cover fill: release reset -> busy=1 for 16 cycles; then reads of addresses 0..15 return 0x00000000.
REQ-032 SHALL cover masked write: write 0xAABBCCDD mask 4'b1111 to addr 3, then 0x11223344 mask 4'b0101 -> port 1 read of addr 3 returns 0xAA22CC44.
REQ-033 SHALL cover latency: OUT_REG=0 and OUT_REG=1, read at cycle N -> dout0_vld at N+1 and N+2 respectively, single-cycle pulse.
REQ-034 SHALL cover collision: addr 5 = 0x0, then same-cycle write 0xFFFFFFFF/read addr 5 -> collision1=1; dout1 = 0x0 (mode 0) or 0xFFFFFFFF (mode 1).
REQ-035 SHALL cover busy: a write issued while busy=1 -> no effect; the address still reads 0 after fill.
REQ-036 SHALL cover reset mid-fill: rstb0 low at fill cycle 7 -> outputs 0; after release busy=1 for a full 16 cycles.
